// File: rtl/adc_conv_scheduler_if.sv
// adc_conv_scheduler_if: start/done handshake bus between the scheduler and the serial ADC engine
interface adc_conv_scheduler_if;
  logic        conv_start;
  logic [2:0]  conv_ch;
  logic        conv_done;
  logic [11:0] conv_data;
  modport master(output conv_start, conv_ch, input conv_done, conv_data);
  modport slave(input conv_start, conv_ch, output conv_done, conv_data);
endinterface

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: arbitrates fast current samples and periodic telemetry scans onto one ADC engine
module adc_conv_scheduler #(
  parameter int          NUM_CH   = 8,
  parameter logic [2:0]  CUR_CH   = 3'd0,
  parameter logic [15:0] SCAN_DIV = 16'd5000,
  parameter logic [11:0] TIMEOUT  = 12'd2000
) (
  input  logic                 Clk_50M_out,
  input  logic                 RST,
  input  logic                 fast_req,
  output logic                 fast_ack,
  output logic [11:0]          fast_data,
  input  logic                 scan_en,
  input  logic [NUM_CH-1:0]    scan_mask,
  adc_conv_scheduler_if.master eng,
  output logic [12*NUM_CH-1:0] ch_data_flat,
  output logic                 scan_done,
  output logic [7:0]           timeout_cnt,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
  state_t               state_q;
  logic                 fast_pend_q, scan_pend_q, scan_active_q, src_fast_q;
  logic                 start_q, fast_ack_q, scan_done_q;
  logic [2:0]           conv_ch_q;
  logic [15:0]          per_q, per_d;
  logic [11:0]          wait_q, data_q, fast_data_q;
  logic [NUM_CH-1:0]    mask_q, mask_clr_d;
  logic [12*NUM_CH-1:0] ch_data_q;
  logic [7:0]           timeout_cnt_q;
  logic [2:0]           low_d;
  logic                 tick_d, last_d;
  assign eng.conv_start = start_q;
  assign eng.conv_ch    = conv_ch_q;
  assign fast_ack       = fast_ack_q;
  assign fast_data      = fast_data_q;
  assign ch_data_flat   = ch_data_q;
  assign scan_done      = scan_done_q;
  assign timeout_cnt    = timeout_cnt_q;
  assign busy           = state_q != IDLE;
  // Scan period tick, lowest remaining scan channel and the mask copy after retiring the current channel
  always_comb begin
    tick_d     = scan_en && per_q == SCAN_DIV - 16'd1;
    per_d      = scan_en ? (tick_d ? '0 : per_q + 16'd1) : '0;
    mask_clr_d = mask_q & ~(NUM_CH'(1) << conv_ch_q);
    last_d     = mask_clr_d == '0;
    low_d      = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (mask_q[i]) low_d = 3'(i);
  end
  // Conversion sequencer; request flags are set after the FSM so a new request wins over a same-cycle clear
  always_ff @(posedge Clk_50M_out or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      fast_pend_q   <= 1'b0;
      scan_pend_q   <= 1'b0;
      scan_active_q <= 1'b0;
      src_fast_q    <= 1'b0;
      start_q       <= 1'b0;
      fast_ack_q    <= 1'b0;
      scan_done_q   <= 1'b0;
      conv_ch_q     <= '0;
      per_q         <= '0;
      wait_q        <= '0;
      data_q        <= '0;
      fast_data_q   <= '0;
      mask_q        <= '0;
      ch_data_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      per_q       <= per_d;
      start_q     <= 1'b0;
      fast_ack_q  <= 1'b0;
      scan_done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (fast_pend_q) begin
            fast_pend_q <= 1'b0;
            conv_ch_q   <= CUR_CH;
            src_fast_q  <= 1'b1;
            start_q     <= 1'b1;
            state_q     <= ISSUE;
          end else if (!scan_en) begin
            scan_active_q <= 1'b0;
            scan_pend_q   <= 1'b0;
          end else if (scan_active_q) begin
            conv_ch_q  <= low_d;
            src_fast_q <= 1'b0;
            start_q    <= 1'b1;
            state_q    <= ISSUE;
          end else if (scan_pend_q) begin
            scan_pend_q   <= 1'b0;
            mask_q        <= scan_mask;
            scan_active_q <= |scan_mask;
          end
        ISSUE: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT:
          if (eng.conv_done) begin
            data_q  <= eng.conv_data;
            state_q <= STORE;
          end else if (wait_q == TIMEOUT - 12'd1) begin
            timeout_cnt_q <= timeout_cnt_q + 8'(~&timeout_cnt_q);
            if (!src_fast_q) begin
              mask_q <= mask_clr_d;
              if (last_d) begin
                scan_active_q <= 1'b0;
                scan_done_q   <= scan_en;
              end
            end
            state_q <= IDLE;
          end else
            wait_q <= wait_q + 12'd1;
        STORE: begin
          ch_data_q[12*conv_ch_q +: 12] <= data_q;
          if (src_fast_q) begin
            fast_data_q <= data_q;
            fast_ack_q  <= 1'b1;
          end else begin
            mask_q <= mask_clr_d;
            if (last_d) begin
              scan_active_q <= 1'b0;
              scan_done_q   <= scan_en;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (fast_req) fast_pend_q <= 1'b1;
      if (tick_d) scan_pend_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: scoreboard bench with a behavioural ADC engine for adc_conv_scheduler
module tb_adc_conv_scheduler;
  localparam logic [15:0] DIV = 16'd400;
  localparam logic [11:0] TO  = 12'd20;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fast_req, fast_ack, scan_en, scan_done, busy;
  logic [11:0] fast_data;
  logic [7:0]  scan_mask, timeout_cnt;
  logic [95:0] ch_data_flat;
  adc_conv_scheduler_if bus();
  adc_conv_scheduler #(.NUM_CH(8), .CUR_CH(3'd0), .SCAN_DIV(DIV), .TIMEOUT(TO)) dut (
    .Clk_50M_out(clk), .RST(rst_n), .fast_req(fast_req), .fast_ack(fast_ack), .fast_data(fast_data),
    .scan_en(scan_en), .scan_mask(scan_mask), .eng(bus), .ch_data_flat(ch_data_flat),
    .scan_done(scan_done), .timeout_cnt(timeout_cnt), .busy(busy)
  );
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int start_cnt = 0, ack_cnt = 0, done_cnt = 0;
  int last_start_cyc = 0, last_done_cyc = 0, last_ack_cyc = 0, last_sdone_cyc = 0;
  logic [2:0]  exp_ch[$];
  logic [11:0] exp_fast[$];
  logic [2:0]  e_ch, eng_ch;
  logic [11:0] e_fast;
  bit          eng_on = 1'b1;
  int          eng_lat = 20;
  logic [11:0] fast_val = 12'h000, scan_base = 12'h100;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // ADC engine: answers each conv_start after eng_lat cycles unless switched off
  always begin
    @(negedge clk);
    if (rst_n && bus.conv_start && eng_on) begin
      eng_ch = bus.conv_ch;
      repeat (eng_lat) @(posedge clk);
      #1 bus.conv_data = (eng_ch == 3'd0) ? fast_val : scan_base + {9'd0, eng_ch};
      bus.conv_done = 1'b1;
      @(posedge clk);
      #1 bus.conv_done = 1'b0;
    end
  end
  // Scoreboard side: pop expected channel / fast result as the DUT produces them
  always @(negedge clk) if (rst_n) begin
    if (bus.conv_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      n_cmp++;
      if (exp_ch.size() == 0) begin
        n_fail++;
        $display("FAIL conv_start_unexpected got ch %0d want none", bus.conv_ch);
      end else begin
        e_ch = exp_ch.pop_front();
        if (bus.conv_ch !== e_ch) begin
          n_fail++;
          $display("FAIL conv_ch_order got %0d want %0d", bus.conv_ch, e_ch);
        end
      end
    end
    if (bus.conv_done) last_done_cyc = cyc;
    if (fast_ack) begin
      ack_cnt++;
      last_ack_cyc = cyc;
      n_cmp++;
      if (exp_fast.size() == 0) begin
        n_fail++;
        $display("FAIL fast_ack_unexpected got data %h want none", fast_data);
      end else begin
        e_fast = exp_fast.pop_front();
        if (fast_data !== e_fast) begin
          n_fail++;
          $display("FAIL fast_data got %h want %h", fast_data, e_fast);
        end
      end
    end
    if (scan_done) begin
      done_cnt++;
      last_sdone_cyc = cyc;
    end
  end
  task automatic pulse_fast(output int n);
    @(posedge clk);
    #1 fast_req = 1'b1;
    n = cyc;
    @(posedge clk);
    #1 fast_req = 1'b0;
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = !busy;
    end
  endtask
  task automatic wait_sdone(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = done_cnt >= target;
    end
  endtask
  task automatic wait_starts(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = start_cnt >= target;
    end
  endtask
  task automatic set_scan(input logic en);
    @(posedge clk);
    #1 scan_en = en;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if ({busy, bus.conv_start, fast_ack, scan_done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, bus.conv_start, fast_ack, scan_done}); end
    if (ch_data_flat !== 96'd0) begin n_fail++; $display("FAIL reset_ch_data got %h want 0", ch_data_flat); end
    if (fast_data !== 12'd0 || bus.conv_ch !== 3'd0) begin n_fail++; $display("FAIL reset_fast_data_ch got %h/%0d want 0/0", fast_data, bus.conv_ch); end
    if (timeout_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_timeout_cnt got %0d want 0", timeout_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask
  task automatic run_fast(input string tag, input logic [11:0] val);
    int n, a0;
    bit ok;
    fast_val = val;
    eng_on = 1'b1;
    a0 = ack_cnt;
    exp_ch.push_back(3'd0);
    exp_fast.push_back(val);
    pulse_fast(n);
    repeat (3) @(negedge clk);
    wait_idle(100, ok);
    repeat (2) @(negedge clk);
    n_cmp += 5;
    if (!ok) begin n_fail++; $display("FAIL %s_idle got busy want idle within 100 cycles", tag); end
    if (last_start_cyc !== n + 2) begin n_fail++; $display("FAIL %s_start_latency got %0d want %0d", tag, last_start_cyc - n, 2); end
    if (last_ack_cyc !== last_done_cyc + 2) begin n_fail++; $display("FAIL %s_ack_latency got %0d want 2", tag, last_ack_cyc - last_done_cyc); end
    if (ack_cnt !== a0 + 1) begin n_fail++; $display("FAIL %s_ack_count got %0d want %0d", tag, ack_cnt - a0, 1); end
    if (ch_data_flat[11:0] !== val) begin n_fail++; $display("FAIL %s_ch0_data got %h want %h", tag, ch_data_flat[11:0], val); end
  endtask
  task automatic test_fast;
    run_fast("fast", 12'hABC);
  endtask
  task automatic test_scan;
    int d0, t1;
    bit ok1, ok2;
    scan_base = 12'h100;
    scan_mask = 8'hA4;
    d0 = done_cnt;
    for (int r = 0; r < 2; r++) begin
      exp_ch.push_back(3'd2);
      exp_ch.push_back(3'd5);
      exp_ch.push_back(3'd7);
    end
    set_scan(1'b1);
    wait_sdone(d0 + 1, 1000, ok1);
    t1 = last_sdone_cyc;
    wait_sdone(d0 + 2, 1000, ok2);
    set_scan(1'b0);
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL scan_done_seen got %b%b want 11", ok1, ok2); end
    if (last_sdone_cyc - t1 !== int'(DIV)) begin n_fail++; $display("FAIL scan_period got %0d want %0d", last_sdone_cyc - t1, DIV); end
    if (ch_data_flat[35:24] !== 12'h102) begin n_fail++; $display("FAIL scan_ch2 got %h want 102", ch_data_flat[35:24]); end
    if (ch_data_flat[71:60] !== 12'h105) begin n_fail++; $display("FAIL scan_ch5 got %h want 105", ch_data_flat[71:60]); end
    if (ch_data_flat[95:84] !== 12'h107) begin n_fail++; $display("FAIL scan_ch7 got %h want 107", ch_data_flat[95:84]); end
    if (exp_ch.size() !== 0) begin n_fail++; $display("FAIL scan_pending_convs got %0d want 0", exp_ch.size()); end
  endtask
  task automatic test_preempt;
    int s0, d0, n;
    bit ok1, ok2;
    s0 = start_cnt;
    d0 = done_cnt;
    fast_val = 12'h5A5;
    scan_mask = 8'hA4;
    exp_ch.push_back(3'd2);
    set_scan(1'b1);
    wait_starts(s0 + 1, 600, ok1);
    repeat (5) @(posedge clk);
    exp_ch.push_back(3'd0);
    exp_ch.push_back(3'd5);
    exp_ch.push_back(3'd7);
    exp_fast.push_back(12'h5A5);
    pulse_fast(n);
    wait_sdone(d0 + 1, 600, ok2);
    set_scan(1'b0);
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL preempt_progress got %b%b want 11", ok1, ok2); end
    if (exp_ch.size() !== 0 || exp_fast.size() !== 0) begin n_fail++; $display("FAIL preempt_pending got %0d/%0d want 0/0", exp_ch.size(), exp_fast.size()); end
    if (ch_data_flat[11:0] !== 12'h5A5) begin n_fail++; $display("FAIL preempt_ch0 got %h want 5A5", ch_data_flat[11:0]); end
    if (ch_data_flat[71:60] !== 12'h105) begin n_fail++; $display("FAIL preempt_ch5 got %h want 105", ch_data_flat[71:60]); end
  endtask
  task automatic test_timeout;
    int n, a0, idle_cyc, bad;
    bit ok;
    eng_on = 1'b0;
    a0 = ack_cnt;
    exp_ch.push_back(3'd0);
    pulse_fast(n);
    repeat (3) @(negedge clk);
    wait_idle(100, ok);
    idle_cyc = cyc;
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL timeout_idle got busy want idle within 100 cycles"); end
    if (idle_cyc !== n + 2 + int'(TO) + 1) begin n_fail++; $display("FAIL timeout_duration got %0d want %0d", idle_cyc - n, 2 + int'(TO) + 1); end
    if (timeout_cnt !== 8'd1) begin n_fail++; $display("FAIL timeout_cnt_first got %0d want 1", timeout_cnt); end
    bad = 0;
    for (int k = 0; k < 299; k++) begin
      exp_ch.push_back(3'd0);
      pulse_fast(n);
      repeat (3) @(negedge clk);
      wait_idle(60, ok);
      if (!ok) bad++;
    end
    repeat (2) @(negedge clk);
    n_cmp += 3;
    if (bad !== 0) begin n_fail++; $display("FAIL timeout_loop_idle got %0d hung want 0", bad); end
    if (timeout_cnt !== 8'd255) begin n_fail++; $display("FAIL timeout_cnt_sat got %0d want 255", timeout_cnt); end
    if (ack_cnt !== a0) begin n_fail++; $display("FAIL timeout_no_ack got %0d acks want 0", ack_cnt - a0); end
    eng_on = 1'b1;
  endtask
  task automatic test_empty_mask;
    int s0, d0;
    s0 = start_cnt;
    d0 = done_cnt;
    scan_mask = 8'h00;
    set_scan(1'b1);
    repeat (2 * int'(DIV) + 20) @(negedge clk);
    set_scan(1'b0);
    repeat (2) @(negedge clk);
    n_cmp += 2;
    if (start_cnt !== s0) begin n_fail++; $display("FAIL empty_mask_starts got %0d want 0", start_cnt - s0); end
    if (done_cnt !== d0) begin n_fail++; $display("FAIL empty_mask_done got %0d want 0", done_cnt - d0); end
  endtask
  task automatic test_disable;
    int s0, d0;
    bit ok;
    s0 = start_cnt;
    d0 = done_cnt;
    scan_base = 12'h200;
    scan_mask = 8'hA4;
    exp_ch.push_back(3'd2);
    exp_ch.push_back(3'd5);
    set_scan(1'b1);
    wait_starts(s0 + 2, 800, ok);
    repeat (3) @(posedge clk);
    #1 scan_en = 1'b0;
    repeat (60) @(negedge clk);
    n_cmp += 6;
    if (!ok) begin n_fail++; $display("FAIL disable_reach_ch5 got %0d starts want 2", start_cnt - s0); end
    if (ch_data_flat[71:60] !== 12'h205) begin n_fail++; $display("FAIL disable_ch5 got %h want 205", ch_data_flat[71:60]); end
    if (ch_data_flat[95:84] !== 12'h107) begin n_fail++; $display("FAIL disable_ch7 got %h want 107", ch_data_flat[95:84]); end
    if (done_cnt !== d0) begin n_fail++; $display("FAIL disable_no_done got %0d want 0", done_cnt - d0); end
    if (exp_ch.size() !== 0) begin n_fail++; $display("FAIL disable_pending got %0d want 0", exp_ch.size()); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL disable_idle got %b want 0", busy); end
  endtask
  task automatic test_async_reset;
    int n;
    eng_on = 1'b0;
    exp_ch.push_back(3'd0);
    pulse_fast(n);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL async_pre_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if ({busy, bus.conv_start, fast_ack, scan_done, timeout_cnt} !== 12'd0) begin n_fail++; $display("FAIL async_flags got %h want 0", {busy, bus.conv_start, fast_ack, scan_done, timeout_cnt}); end
    if (ch_data_flat !== 96'd0) begin n_fail++; $display("FAIL async_ch_data got %h want 0", ch_data_flat); end
    if (fast_data !== 12'd0) begin n_fail++; $display("FAIL async_fast_data got %h want 0", fast_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_fast("post_reset", 12'h3C3);
    n_cmp++;
    if (ch_data_flat[95:12] !== 84'd0) begin n_fail++; $display("FAIL post_reset_other_ch got %h want 0", ch_data_flat[95:12]); end
  endtask
  initial begin
    fast_req = 1'b0;
    scan_en = 1'b0;
    scan_mask = 8'h00;
    bus.conv_done = 1'b0;
    bus.conv_data = 12'h000;
    test_reset;
    test_fast;
    test_scan;
    test_preempt;
    test_timeout;
    test_empty_mask;
    test_disable;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #800000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
